// File: rtl/dependence_stream.sv
// rtl/dependence_stream.sv - pipelined bitwise dependence function with valid/ready flow control
module dependence_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           port_a,
    input  logic [WIDTH-1:0]           port_b,
    input  logic [WIDTH-1:0]           port_c,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_q,
    output logic [$clog2(WIDTH+1)-1:0] out_cnt,
    output logic [CNT_W-1:0]           hit_count,
    input  logic                       hit_clr
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] HIT_MAX = '1;

    logic [DEPTH-1:0] stage_v;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] stage_q   [DEPTH];
    logic [CW-1:0]    stage_cnt [DEPTH];
    logic [WIDTH-1:0] func_q;
    logic [CW-1:0]    func_cnt;

    // Mode-selected bitwise function of the presented operands
    always_comb begin
        func_q = '0;
        case (mode)
            2'd0:    func_q = port_b & (port_a | port_c);
            2'd1:    func_q = port_a & port_b;
            2'd2:    func_q = port_a | port_b | port_c;
            2'd3:    func_q = port_a ^ port_b ^ port_c;
            default: func_q = '0;
        endcase
    end

    // Popcount of the function result, carried down the pipe with the word
    always_comb begin
        func_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            func_cnt = func_cnt + CW'(func_q[i]);
        end
    end

    // Load chain: a stage loads when empty or when the stage after it moves on
    always_comb begin
        logic carry;
        load  = '0;
        carry = !stage_v[DEPTH-1] || out_ready;
        load[DEPTH-1] = carry;
        for (int s = DEPTH-2; s >= 0; s--) begin
            carry   = !stage_v[s] || carry;
            load[s] = carry;
        end
    end

    // Stage registers; data only changes when a valid word arrives, so the
    // output word holds its last value across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_v <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s]   <= '0;
                stage_cnt[s] <= '0;
            end
        end else begin
            if (load[0]) begin
                stage_v[0] <= in_valid;
                if (in_valid) begin
                    stage_q[0]   <= func_q;
                    stage_cnt[0] <= func_cnt;
                end
            end
            for (int s = 1; s < DEPTH; s++) begin
                if (load[s]) begin
                    stage_v[s] <= stage_v[s-1];
                    if (stage_v[s-1]) begin
                        stage_q[s]   <= stage_q[s-1];
                        stage_cnt[s] <= stage_cnt[s-1];
                    end
                end
            end
        end
    end

    // Saturating count of nonzero results leaving the block; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (hit_clr) begin
            hit_count <= '0;
        end else if (out_valid && out_ready && (out_q != '0) && (hit_count != HIT_MAX)) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

    assign in_ready  = load[0];
    assign out_valid = stage_v[DEPTH-1];
    assign out_q     = stage_q[DEPTH-1];
    assign out_cnt   = stage_cnt[DEPTH-1];

endmodule

// File: tb/tb_dependence_stream.sv
// tb/tb_dependence_stream.sv - scoreboard bench for dependence_stream
module tb_dependence_stream;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [7:0]  port_a, port_b, port_c;
    logic [1:0]  mode;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [7:0]  out_q, out_q2;
    logic [3:0]  out_cnt, out_cnt2;
    logic [15:0] hit_count;
    logic [1:0]  hit_count2;
    logic        hit_clr;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] c;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          m16 = 0;
    int          m2 = 0;

    dependence_stream #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .port_a(port_a), .port_b(port_b), .port_c(port_c), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
        .out_cnt(out_cnt), .hit_count(hit_count), .hit_clr(hit_clr)
    );

    dependence_stream #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .port_a(port_a), .port_b(port_b), .port_c(port_c), .mode(mode),
        .out_valid(out_valid2), .out_ready(out_ready), .out_q(out_q2),
        .out_cnt(out_cnt2), .hit_count(hit_count2), .hit_clr(hit_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_f(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [1:0] m);
        case (m)
            2'd0:    return b & (a | c);
            2'd1:    return a & b;
            2'd2:    return a | b | c;
            default: return a ^ b ^ c;
        endcase
    endfunction

    function automatic exp_t expect_word(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [1:0] m);
        exp_t e;
        e.q = model_f(a, b, c, m);
        e.c = 4'($countones(e.q));
        return e;
    endfunction

    // Output monitor: pops the scoreboard on each output transfer and tracks hit counts
    always @(negedge clk) begin
        if (rst) begin
            m16 = 0;
            m2  = 0;
        end else begin
            check("hit_count", 32'(hit_count), 32'(m16));
            check("hit_count_sat", 32'(hit_count2), 32'(m2));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_q", 32'(out_q), 32'(e.q));
                    check("out_cnt", 32'(out_cnt), 32'(e.c));
                end
            end
            if (hit_clr) begin
                m16 = 0;
                m2  = 0;
            end else if (out_valid && out_ready && out_q != 8'h00) begin
                if (m16 < 65535) m16++;
                if (m2 < 3) m2++;
            end
        end
    end

    // Present one word and hold it until accepted; returns just after the accepting edge
    task automatic send(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [7:0] op_c, input logic [1:0] op_m);
        bit ok;
        ok = 1'b0;
        port_a   = op_a;
        port_b   = op_b;
        port_c   = op_c;
        mode     = op_m;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(expect_word(op_a, op_b, op_c, op_m));
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  acc;
        int  hb;
        int  n_out;
        bit  seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        hit_clr   = 1'b0;
        port_a    = '0;
        port_b    = '0;
        port_c    = '0;
        mode      = '0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single word, latency
        send(8'hF0, 8'hCC, 8'h0F, 2'd0);
        in_valid = 1'b0;
        acc  = cyc;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("latency_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc - acc), 32'(DEPTH - 1));
        check("first_q", 32'(out_q), 32'hCC);
        drain();
        check("first_hit", 32'(hit_count), 32'd1);

        // Back-to-back, one word per mode
        for (int m = 0; m < 4; m++) send(8'hF0, 8'hCC, 8'h0F, 2'(m));
        in_valid = 1'b0;
        drain();

        // Stall: two words fill the pipe, third is refused until out_ready rises
        out_ready = 1'b0;
        send(8'hF0, 8'hCC, 8'h0F, 2'd1);
        send(8'hF0, 8'hCC, 8'h0F, 2'd2);
        mode = 2'd3;
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("stall_q", 32'(out_q), 32'hC0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_hold_q", 32'(out_q), 32'hC0);
            check("stall_hold_cnt", 32'(out_cnt), 32'd2);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("full_pass_in_ready", 32'(in_ready), 32'd1);
        check("nogap0", 32'(out_valid), 32'd1);
        if (in_ready) sb.push_back(expect_word(8'hF0, 8'hCC, 8'h0F, 2'd3));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("nogap1", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("nogap2", 32'(out_valid), 32'd1);
        drain();

        // Zero result leaves hit_count unchanged
        hb = int'(hit_count);
        send(8'h00, 8'hFF, 8'h00, 2'd0);
        in_valid = 1'b0;
        drain();
        check("zero_hit", 32'(hit_count), 32'(hb));

        // Clear, then saturate the 2-bit counter
        hit_clr = 1'b1;
        @(posedge clk);
        #1 hit_clr = 1'b0;
        @(negedge clk);
        check("clr_hit", 32'(hit_count), 32'd0);
        check("clr_hit_sat", 32'(hit_count2), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(8'hF0, 8'hCC, 8'h0F, 2'(i % 4));
        in_valid = 1'b0;
        drain();
        check("sat_hit16", 32'(hit_count), 32'd5);
        check("sat_hit2", 32'(hit_count2), 32'd3);

        // Clear coinciding with a hit
        send(8'hF0, 8'hCC, 8'h0F, 2'd1);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("clr_wait", 32'(seen), 32'd1);
        hit_clr = 1'b1;
        @(posedge clk);
        #1 hit_clr = 1'b0;
        @(negedge clk);
        check("clr_vs_hit16", 32'(hit_count), 32'd0);
        check("clr_vs_hit2", 32'(hit_count2), 32'd0);
        drain();

        // Reset with words in flight
        for (int i = 0; i < 3; i++) send(8'hF0, 8'hCC, 8'h0F, 2'(i));
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_hit", 32'(hit_count), 32'd0);
        check("midrst_hit_sat", 32'(hit_count2), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) n_out++;
        end
        check("post_rst_no_out", 32'(n_out), 32'd0);
        check("post_rst_hit", 32'(hit_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
